// File: rtl/muldiv_unit.sv
// Iterative RV32M/RV64M multiply/divide unit: shift-add multiply and restoring divide
// over XLEN cycles, one-cycle fast path for division corner cases, valid/ready handshake.
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_flush,
    input  logic            i_in_valid,
    output logic            o_in_ready,
    input  logic [2:0]      i_funct3,
    input  logic [XLEN-1:0] i_a,
    input  logic [XLEN-1:0] i_b,
    output logic            o_out_valid,
    input  logic            i_out_ready,
    output logic [XLEN-1:0] o_result,
    output logic            o_busy
);

    localparam int CW = $clog2(XLEN + 1);
    localparam logic [CW-1:0]   LP_ITER = CW'(XLEN);
    localparam logic [CW-1:0]   LP_ONE  = CW'(1);
    localparam logic [XLEN-1:0] LP_MIN  = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t            r_state;
    state_t            w_nextState;
    logic [CW-1:0]     r_count;
    logic [2:0]        r_op;
    logic              r_negX;
    logic              r_negR;
    logic [XLEN-1:0]   r_hi;
    logic [XLEN-1:0]   r_lo;
    logic [XLEN-1:0]   r_opnd;
    logic [XLEN-1:0]   r_result;

    logic              w_isDiv;
    logic              w_signA;
    logic              w_signB;
    logic [XLEN-1:0]   w_magA;
    logic [XLEN-1:0]   w_magB;
    logic              w_bZero;
    logic              w_ovf;
    logic              w_fast;
    logic [XLEN-1:0]   w_fastResult;
    logic              w_accept;

    logic [XLEN:0]     w_sum;
    logic [XLEN:0]     w_shift;
    logic              w_qbit;
    logic [XLEN-1:0]   w_diff;
    logic [XLEN-1:0]   w_nextHi;
    logic [XLEN-1:0]   w_nextLo;
    logic [2*XLEN-1:0] w_prod;
    logic [2*XLEN-1:0] w_prodS;
    logic [XLEN-1:0]   w_quot;
    logic [XLEN-1:0]   w_rem;
    logic [XLEN-1:0]   w_final;

    // Operand decode on the request: MUL/MULH/MULHSU treat A as signed, only MUL/MULH treat B as signed.
    assign w_isDiv = i_funct3[2];
    assign w_signA = i_a[XLEN-1] & (w_isDiv ? ~i_funct3[0] : (i_funct3[1:0] != 2'b11));
    assign w_signB = i_b[XLEN-1] & (w_isDiv ? ~i_funct3[0] : ~i_funct3[1]);
    assign w_magA  = w_signA ? -i_a : i_a;
    assign w_magB  = w_signB ? -i_b : i_b;

    assign w_bZero      = (i_b == '0);
    assign w_ovf        = ~i_funct3[0] & (i_a == LP_MIN) & (i_b == '1);
    assign w_fast       = w_isDiv & (w_bZero | w_ovf);
    assign w_fastResult = w_bZero ? (i_funct3[1] ? i_a : '1) : (i_funct3[1] ? '0 : i_a);
    assign w_accept     = (r_state == IDLE) & i_in_valid & ~i_flush;

    // r_hi/r_lo hold {partial product, multiplier} for multiply and {remainder, dividend/quotient} for divide.
    assign w_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opnd} : '0);
    assign w_shift = {r_hi, r_lo[XLEN-1]};
    assign w_qbit  = (w_shift >= {1'b0, r_opnd});
    assign w_diff  = w_shift[XLEN-1:0] - r_opnd;

    assign w_nextHi = r_op[2] ? (w_qbit ? w_diff : w_shift[XLEN-1:0]) : w_sum[XLEN:1];
    assign w_nextLo = r_op[2] ? {r_lo[XLEN-2:0], w_qbit} : {w_sum[0], r_lo[XLEN-1:1]};

    assign w_prod  = {w_nextHi, w_nextLo};
    assign w_prodS = r_negX ? -w_prod : w_prod;
    assign w_quot  = r_negX ? -w_nextLo : w_nextLo;
    assign w_rem   = r_negR ? -w_nextHi : w_nextHi;
    assign w_final = r_op[2] ? (r_op[1] ? w_rem : w_quot)
                             : ((r_op[1:0] == 2'b00) ? w_prodS[XLEN-1:0] : w_prodS[2*XLEN-1:XLEN]);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Flush overrides every transition, including a same-cycle request or result handover.
    always_comb begin
        w_nextState = r_state;
        o_in_ready  = 1'b0;
        o_out_valid = 1'b0;
        o_busy      = 1'b0;
        case (r_state)
            IDLE: begin
                o_in_ready = 1'b1;
                if (i_in_valid) begin
                    w_nextState = w_fast ? DONE : BUSY;
                end
            end
            BUSY: begin
                o_busy = 1'b1;
                if (r_count == LP_ONE) begin
                    w_nextState = DONE;
                end
            end
            DONE: begin
                o_out_valid = 1'b1;
                o_busy      = 1'b1;
                if (i_out_ready) begin
                    w_nextState = IDLE;
                end
            end
            default: w_nextState = IDLE;
        endcase
        if (i_flush) begin
            w_nextState = IDLE;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count  <= '0;
            r_op     <= '0;
            r_negX   <= 1'b0;
            r_negR   <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_opnd   <= '0;
            r_result <= '0;
        end else if (w_accept) begin
            r_op <= i_funct3;
            if (w_fast) begin
                r_result <= w_fastResult;
            end else begin
                r_count <= LP_ITER;
                r_negX  <= w_signA ^ w_signB;
                r_negR  <= w_signA;
                r_hi    <= '0;
                r_lo    <= w_isDiv ? w_magA : w_magB;
                r_opnd  <= w_isDiv ? w_magB : w_magA;
            end
        end else if ((r_state == BUSY) && !i_flush) begin
            r_hi    <= w_nextHi;
            r_lo    <= w_nextLo;
            r_count <= r_count - LP_ONE;
            if (r_count == LP_ONE) begin
                r_result <= w_final;
            end
        end
    end

    assign o_result = r_result;

endmodule

// File: tb/tb_muldiv_unit.sv
// Randomized and directed bench for muldiv_unit, compared against an arithmetic reference model.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rstN;
    logic        flush;
    logic        inValid;
    logic        inReady;
    logic [2:0]  funct3;
    logic [31:0] opA;
    logic [31:0] opB;
    logic        outValid;
    logic        outReady;
    logic [31:0] result;
    logic        busy;

    logic        flushWide;
    logic        inValidWide;
    logic        inReadyWide;
    logic [2:0]  funct3Wide;
    logic [63:0] aWide;
    logic [63:0] bWide;
    logic        outValidWide;
    logic        outReadyWide;
    logic [63:0] resultWide;
    logic        busyWide;

    int checkCount = 0;
    int errorCount = 0;

    always #5 clk = ~clk;

    muldiv_unit #(.XLEN(32)) dut (
        .i_clk(clk), .i_rst_n(rstN), .i_flush(flush), .i_in_valid(inValid),
        .o_in_ready(inReady), .i_funct3(funct3), .i_a(opA), .i_b(opB),
        .o_out_valid(outValid), .i_out_ready(outReady), .o_result(result), .o_busy(busy)
    );

    muldiv_unit #(.XLEN(64)) dutWide (
        .i_clk(clk), .i_rst_n(rstN), .i_flush(flushWide), .i_in_valid(inValidWide),
        .o_in_ready(inReadyWide), .i_funct3(funct3Wide), .i_a(aWide), .i_b(bWide),
        .o_out_valid(outValidWide), .i_out_ready(outReadyWide), .o_result(resultWide),
        .o_busy(busyWide)
    );

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Reference results straight from the RISC-V M-extension definitions using 64-bit arithmetic.
    function automatic logic [31:0] refModel(input logic [2:0] f, input logic [31:0] a,
                                             input logic [31:0] b);
        longint          sa  = longint'($signed(a));
        longint          sb  = longint'($signed(b));
        longint          ubs = longint'({32'b0, b});
        longint unsigned ua  = {32'b0, a};
        longint unsigned ub  = {32'b0, b};
        logic [63:0]     p;
        case (f)
            3'd0: begin p = sa * sb;  return p[31:0];  end
            3'd1: begin p = sa * sb;  return p[63:32]; end
            3'd2: begin p = sa * ubs; return p[63:32]; end
            3'd3: begin p = ua * ub;  return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                p = sa / sb; return p[31:0];
            end
            3'd5: begin
                if (b == 0) return 32'hFFFF_FFFF;
                p = ua / ub; return p[31:0];
            end
            3'd6: begin
                if (b == 0) return a;
                p = sa % sb; return p[31:0];
            end
            default: begin
                if (b == 0) return a;
                p = ua % ub; return p[31:0];
            end
        endcase
    endfunction

    function automatic int expLatency(input logic [2:0] f, input logic [31:0] a,
                                      input logic [31:0] b);
        if (f[2] && (b == 0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)))
            return 1;
        return 33;
    endfunction

    task automatic waitResult(input string tag, input logic [31:0] expected,
                              input int expLat, input int hold);
        int lat = 0;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            if (outValid) begin
                lat = i;
                break;
            end
        end
        checkOutput({tag, "Latency"}, 64'(lat), 64'(expLat));
        checkOutput({tag, "Result"}, {32'b0, result}, {32'b0, expected});
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            checkOutput({tag, "HoldValid"}, {63'b0, outValid}, 64'd1);
            checkOutput({tag, "HoldResult"}, {32'b0, result}, {32'b0, expected});
            checkOutput({tag, "HoldInReady"}, {63'b0, inReady}, 64'd0);
        end
        outReady = 1'b1;
        @(posedge clk);
        #1;
        outReady = 1'b0;
        @(negedge clk);
        checkOutput({tag, "InReadyAfter"}, {63'b0, inReady}, 64'd1);
        checkOutput({tag, "ValidAfter"}, {63'b0, outValid}, 64'd0);
    endtask

    task automatic applyStimulus(input string tag, input logic [2:0] f, input logic [31:0] a,
                                 input logic [31:0] b, input logic [31:0] expected,
                                 input int hold);
        @(negedge clk);
        funct3  = f;
        opA     = a;
        opB     = b;
        inValid = 1'b1;
        checkOutput({tag, "Ready"}, {63'b0, inReady}, 64'd1);
        @(posedge clk);
        #1;
        inValid = 1'b0;
        funct3  = 3'($urandom);
        opA     = $urandom;
        opB     = $urandom;
        waitResult(tag, expected, expLatency(f, a, b), hold);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [2:0]  dirF   [12] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd6, 3'd5, 3'd7,
                                     3'd4, 3'd7, 3'd4, 3'd6};
        logic [31:0] dirA   [12] = '{32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'hFFFF_FFFE,
                                     32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd20, 32'd20,
                                     32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
        logic [31:0] dirB   [12] = '{32'd3, 32'd3, 32'd3, 32'd3, 32'd2, 32'd2, 32'd30, 32'd30,
                                     32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] dirExp [12] = '{32'hFFFF_FFFA, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0002,
                                     32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd0, 32'd20,
                                     32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0};
        logic [2:0]  nf;
        logic [31:0] na;
        logic [31:0] nb;
        logic [31:0] rb;
        int          lat;

        rstN = 1'b0; flush = 1'b0; inValid = 1'b0; outReady = 1'b0;
        funct3 = '0; opA = '0; opB = '0;
        flushWide = 1'b0; inValidWide = 1'b0; outReadyWide = 1'b0;
        funct3Wide = '0; aWide = '0; bWide = '0;

        @(negedge clk);
        checkOutput("resetInReady", {63'b0, inReady}, 64'd1);
        checkOutput("resetOutValid", {63'b0, outValid}, 64'd0);
        checkOutput("resetBusy", {63'b0, busy}, 64'd0);
        checkOutput("resetResult", {32'b0, result}, 64'd0);
        rstN = 1'b1;

        for (int i = 0; i < 12; i++) begin
            applyStimulus($sformatf("dir%0d", i), dirF[i], dirA[i], dirB[i], dirExp[i], 0);
        end

        applyStimulus("backpressure", 3'd1, 32'h1234_5678, 32'h9ABC_DEF0,
                      refModel(3'd1, 32'h1234_5678, 32'h9ABC_DEF0), 10);

        // Flush in the 12th BUSY cycle with a competing request in the same cycle.
        @(negedge clk);
        funct3 = 3'd0; opA = $urandom; opB = $urandom; inValid = 1'b1;
        @(posedge clk);
        #1;
        inValid = 1'b0;
        repeat (12) @(negedge clk);
        checkOutput("flushBusyBefore", {63'b0, busy}, 64'd1);
        nf = 3'd3; na = $urandom; nb = $urandom;
        flush = 1'b1; inValid = 1'b1; funct3 = nf; opA = na; opB = nb;
        @(negedge clk);
        checkOutput("flushOutValid", {63'b0, outValid}, 64'd0);
        checkOutput("flushBusy", {63'b0, busy}, 64'd0);
        checkOutput("flushInReady", {63'b0, inReady}, 64'd1);
        @(negedge clk);
        checkOutput("flushBlocksAccept", {63'b0, busy}, 64'd0);
        flush = 1'b0;
        @(posedge clk);
        #1;
        inValid = 1'b0;
        waitResult("afterFlush", refModel(nf, na, nb), 33, 0);

        // Asynchronous reset in the middle of a division.
        @(negedge clk);
        funct3 = 3'd5; opA = $urandom; opB = 32'd7; inValid = 1'b1;
        @(posedge clk);
        #1;
        inValid = 1'b0;
        repeat (5) @(negedge clk);
        #2;
        rstN = 1'b0;
        #1;
        checkOutput("midResetOutValid", {63'b0, outValid}, 64'd0);
        checkOutput("midResetInReady", {63'b0, inReady}, 64'd1);
        checkOutput("midResetBusy", {63'b0, busy}, 64'd0);
        checkOutput("midResetResult", {32'b0, result}, 64'd0);
        @(negedge clk);
        rstN = 1'b1;

        for (int i = 0; i < 40; i++) begin
            logic [2:0]  rf = 3'($urandom_range(0, 7));
            logic [31:0] ra = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
            case ($urandom_range(0, 4))
                0:       rb = 32'd0;
                1:       rb = 32'hFFFF_FFFF;
                2:       rb = $urandom_range(1, 15);
                default: rb = $urandom;
            endcase
            applyStimulus($sformatf("rand%0d", i), rf, ra, rb, refModel(rf, ra, rb), 0);
        end

        // 64-bit instance: MULHU of all-ones squared.
        @(negedge clk);
        funct3Wide = 3'd3; aWide = '1; bWide = '1; inValidWide = 1'b1;
        @(posedge clk);
        #1;
        inValidWide = 1'b0;
        aWide = '0; bWide = '0;
        lat = 0;
        for (int i = 1; i <= 200; i++) begin
            @(negedge clk);
            if (outValidWide) begin
                lat = i;
                break;
            end
        end
        checkOutput("wideLatency", 64'(lat), 64'd65);
        checkOutput("wideResult", resultWide, 64'hFFFF_FFFF_FFFF_FFFE);
        outReadyWide = 1'b1;
        @(posedge clk);
        #1;
        outReadyWide = 1'b0;
        @(negedge clk);
        checkOutput("wideInReadyAfter", {63'b0, inReadyWide}, 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
